// File: rtl/axis_merge_pkg.sv
// Shared types and helpers for the AXI-Stream length-merge block.
//   CNT_W_DEF      : default width of the packet beat counter and error counters
//   DSIZE_DEF      : default tdata width; KSIZE_DEF follows as one keep bit per byte
//   skid_payload_t : beat payload carried through the output skid, default widths
//   sat_inc()      : increment that sticks at a caller-supplied ceiling
package axis_merge_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DSIZE_DEF = 8;
  localparam int KSIZE_DEF = DSIZE_DEF / 8;

  typedef struct packed {
    logic [DSIZE_DEF-1:0] tdata;
    logic [KSIZE_DEF-1:0] tkeep;
    logic                 tlast;
  } skid_payload_t;

  // Saturating increment; the ceiling is passed in so any counter width up to 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max_val);
    logic [31:0] result;
    if (count >= max_val) begin
      result = max_val;
    end else begin
      result = count + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_skid_pipe.sv
// Two-entry register skid buffer for a valid/ready stream.
//   clock     : sole clock
//   rst       : synchronous active-high reset, empties both entries
//   in_valid  : upstream valid;  in_ready  : upstream ready (registered, low when full)
//   in_data   : upstream payload (PW bits)
//   out_valid : downstream valid (registered); out_ready : downstream ready
//   out_data  : downstream payload (registered)
// A beat written into an empty buffer appears on the output the next cycle.
module axis_skid_pipe #(
  parameter int PW = 10
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          head_valid_r, head_valid_s;
  logic [PW-1:0] head_data_r, head_data_s;
  logic          skid_valid_r, skid_valid_s;
  logic [PW-1:0] skid_data_r, skid_data_s;
  logic          ready_r;
  logic          wr_s, rd_s;

  // Next-state of the two entries: head feeds the output, skid catches a beat while head stalls.
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    wr_s         = in_valid & ready_r;
    rd_s         = head_valid_r & out_ready;
    if (skid_valid_r) begin
      // Full: ready_r is low so no write can arrive; a read promotes skid into head.
      if (rd_s) begin
        head_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
      end else begin
        head_data_s  = head_data_r;
      end
    end else if (head_valid_r) begin
      if (rd_s && wr_s) begin
        head_data_s  = in_data;
      end else if (rd_s) begin
        head_valid_s = 1'b0;
      end else if (wr_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = in_data;
      end else begin
        head_valid_s = head_valid_r;
      end
    end else begin
      if (wr_s) begin
        head_valid_s = 1'b1;
        head_data_s  = in_data;
      end else begin
        head_valid_s = 1'b0;
      end
    end
  end

  // Entry registers plus the registered ready, which drops as soon as both entries will be occupied.
  always_ff @(posedge clock) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      ready_r      <= 1'b0;
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      ready_r      <= ~(head_valid_s & skid_valid_s);
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = head_valid_r;
  assign out_data  = head_data_r;

endmodule

// File: rtl/axis_length_merge_with_user.sv
// Rebuilds original packets from a stream cut into fixed-length chunks.
// Chunk ends (tlast) are dropped; the original packet end (tuser) becomes the output tlast.
//   clock, rst        : sole clock, synchronous active-high reset
//   length            : expected chunk length in beats, 0 disables the length check
//   axis_in_*         : chunked input stream (tuser = original packet end)
//   axis_out_*        : merged output stream through a 2-entry skid (1-cycle latency)
//   pkt_done, pkt_len : pulse and beat count for every merged packet end accepted
//   short_err_cnt     : saturating count of non-final chunks shorter than length
//   long_err_cnt      : saturating count of chunks running past length without tlast
module axis_length_merge_with_user
  import axis_merge_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int KSIZE = DSIZE / 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [31:0]      length,
  input  logic             axis_in_tvalid,
  output logic             axis_in_tready,
  input  logic [DSIZE-1:0] axis_in_tdata,
  input  logic [KSIZE-1:0] axis_in_tkeep,
  input  logic             axis_in_tlast,
  input  logic             axis_in_tuser,
  output logic             axis_out_tvalid,
  input  logic             axis_out_tready,
  output logic [DSIZE-1:0] axis_out_tdata,
  output logic [KSIZE-1:0] axis_out_tkeep,
  output logic             axis_out_tlast,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_len,
  output logic [CNT_W-1:0] short_err_cnt,
  output logic [CNT_W-1:0] long_err_cnt
);

  localparam int               PW        = DSIZE + KSIZE + 1;
  localparam logic [CNT_W-1:0] CNT_ONES  = '1;
  localparam logic [31:0]      CNT_MAX32 = 32'(CNT_ONES);

  logic             acc_s;
  logic             len_on_s;
  logic [31:0]      chk_cnt_r;
  logic [31:0]      chk_inc_s;
  logic             short_hit_s;
  logic             long_hit_s;
  logic [CNT_W-1:0] pkt_cnt_r;
  logic [CNT_W-1:0] pkt_inc_s;
  logic [CNT_W-1:0] pkt_len_r;
  logic             pkt_done_r;
  logic [CNT_W-1:0] short_err_r;
  logic [CNT_W-1:0] long_err_r;
  logic [PW-1:0]    in_payload_s;
  logic [PW-1:0]    out_payload_s;

  // Output tlast is the original packet end; the chunk tlast goes no further.
  assign in_payload_s = {axis_in_tdata, axis_in_tkeep, axis_in_tuser};

  axis_skid_pipe #(
    .PW (PW)
  ) u_skid (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (axis_in_tvalid),
    .in_ready  (axis_in_tready),
    .in_data   (in_payload_s),
    .out_valid (axis_out_tvalid),
    .out_ready (axis_out_tready),
    .out_data  (out_payload_s)
  );

  assign axis_out_tdata = out_payload_s[PW-1 -: DSIZE];
  assign axis_out_tkeep = out_payload_s[KSIZE:1];
  assign axis_out_tlast = out_payload_s[0];

  // Chunk-length checks use the position this beat would occupy in its chunk.
  always_comb begin
    acc_s       = axis_in_tvalid & axis_in_tready;
    len_on_s    = (length != 32'd0);
    chk_inc_s   = chk_cnt_r + 32'd1;
    short_hit_s = acc_s & len_on_s & axis_in_tlast & ~axis_in_tuser & (chk_inc_s != length);
    long_hit_s  = acc_s & len_on_s & ~axis_in_tlast & ~axis_in_tuser & (chk_inc_s == length);
    pkt_inc_s   = CNT_W'(sat_inc(32'(pkt_cnt_r), CNT_MAX32));
  end

  // Chunk/packet counters, packet-end report and saturating error counters.
  always_ff @(posedge clock) begin
    if (rst) begin
      chk_cnt_r   <= 32'd0;
      pkt_cnt_r   <= '0;
      pkt_len_r   <= '0;
      pkt_done_r  <= 1'b0;
      short_err_r <= '0;
      long_err_r  <= '0;
    end else begin
      pkt_done_r <= 1'b0;
      if (acc_s) begin
        // A long error restarts the chunk count so later chunks can resynchronise.
        if (axis_in_tlast || axis_in_tuser || long_hit_s) begin
          chk_cnt_r <= 32'd0;
        end else begin
          chk_cnt_r <= chk_inc_s;
        end
        if (axis_in_tuser) begin
          pkt_len_r  <= pkt_inc_s;
          pkt_done_r <= 1'b1;
          pkt_cnt_r  <= '0;
        end else begin
          pkt_cnt_r  <= pkt_inc_s;
        end
      end
      if (short_hit_s) begin
        short_err_r <= CNT_W'(sat_inc(32'(short_err_r), CNT_MAX32));
      end
      if (long_hit_s) begin
        long_err_r <= CNT_W'(sat_inc(32'(long_err_r), CNT_MAX32));
      end
    end
  end

  assign pkt_done      = pkt_done_r;
  assign pkt_len       = pkt_len_r;
  assign short_err_cnt = short_err_r;
  assign long_err_cnt  = long_err_r;

endmodule

// File: tb/tb_axis_length_merge_with_user.sv
// Self-checking bench for axis_length_merge_with_user. Packets are described as lists
// of chunk sizes; expected beats, packet lengths and error counts come from those sizes.
module tb_axis_length_merge_with_user;
  import axis_merge_pkg::*;

  localparam int DSIZE = 8;
  localparam int KSIZE = 1;
  localparam int CNT_W = 5;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      length = 32'd4;
  logic             axis_in_tvalid = 1'b0;
  logic             axis_in_tready;
  logic [DSIZE-1:0] axis_in_tdata = '0;
  logic [KSIZE-1:0] axis_in_tkeep = '0;
  logic             axis_in_tlast = 1'b0;
  logic             axis_in_tuser = 1'b0;
  logic             axis_out_tvalid;
  logic             axis_out_tready = 1'b1;
  logic [DSIZE-1:0] axis_out_tdata;
  logic [KSIZE-1:0] axis_out_tkeep;
  logic             axis_out_tlast;
  logic             pkt_done;
  logic [CNT_W-1:0] pkt_len;
  logic [CNT_W-1:0] short_err_cnt;
  logic [CNT_W-1:0] long_err_cnt;

  axis_length_merge_with_user #(
    .DSIZE (DSIZE),
    .KSIZE (KSIZE),
    .CNT_W (CNT_W)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .length          (length),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tkeep   (axis_in_tkeep),
    .axis_in_tlast   (axis_in_tlast),
    .axis_in_tuser   (axis_in_tuser),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .pkt_done        (pkt_done),
    .pkt_len         (pkt_len),
    .short_err_cnt   (short_err_cnt),
    .long_err_cnt    (long_err_cnt)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            errors = 0;
  skid_payload_t exp_q[$];
  skid_payload_t got_q[$];
  int            exp_len_q[$];
  int            got_len_q[$];
  int            exp_short = 0;
  int            exp_long = 0;
  int            last_len = 0;
  int            stall_viol = 0;
  int            ready_mode = 0;
  int            chunk_q[$];
  bit            final_tlast = 1'b1;
  bit            lat_check = 1'b0;
  logic          prev_stall = 1'b0;
  skid_payload_t prev_pl;
  skid_payload_t cur_pl;

  assign cur_pl = {axis_out_tdata, axis_out_tkeep, axis_out_tlast};

  // Output capture and stall-stability watch.
  always @(posedge clock) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (axis_out_tvalid !== 1'b1 || cur_pl !== prev_pl))
        stall_viol <= stall_viol + 1;
      prev_stall <= axis_out_tvalid & ~axis_out_tready;
      prev_pl    <= cur_pl;
      if (axis_out_tvalid && axis_out_tready) got_q.push_back(cur_pl);
      if (pkt_done) got_len_q.push_back(int'(pkt_len));
    end
  end

  // Downstream ready: 0 always ready, 1 toggling, 2 random, 3 held low.
  always @(negedge clock) begin
    case (ready_mode)
      0:       axis_out_tready <= 1'b1;
      1:       axis_out_tready <= ~axis_out_tready;
      2:       axis_out_tready <= 1'($urandom_range(0, 1));
      default: axis_out_tready <= 1'b0;
    endcase
  end

  function automatic int sat_add(input int a, input int b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  // Errors one chunk of s beats produces at chunk length L: a long error at every
  // multiple of L strictly before the last beat; a non-final chunk whose remainder
  // after those restarts is not exactly L is short.
  function automatic void chunk_errors(input int s, input int L, input bit fin,
                                       output int sh, output int lg);
    sh = 0;
    lg = 0;
    if (L != 0) begin
      lg = (s - 1) / L;
      if (!fin && (s - lg * L) != L) sh = 1;
    end
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    int waited;
    bit rdy;
    bit ok;
    waited = 0;
    ok = 1'b0;
    @(negedge clock);
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = d;
    axis_in_tkeep  = k;
    axis_in_tlast  = l;
    axis_in_tuser  = u;
    while (waited < 200) begin
      rdy = axis_in_tready;
      @(posedge clock);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(negedge clock);
    end
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL beat_accept: accepted=%0d required=1 (timeout)", ok);
    end
  endtask

  task automatic idle_input();
    @(negedge clock);
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
    axis_in_tuser  = 1'b0;
  endtask

  // Sends the chunk list in chunk_q as one packet and records what must come out.
  task automatic send_packet(input bit gaps);
    int            total;
    int            sh;
    int            lg;
    bit            fin;
    bit            endb;
    bit            first;
    logic [7:0]    d;
    logic          k;
    skid_payload_t e;
    total = 0;
    first = 1'b1;
    for (int c = 0; c < chunk_q.size(); c++) begin
      fin = (c == chunk_q.size() - 1);
      total += chunk_q[c];
      chunk_errors(chunk_q[c], int'(length), fin, sh, lg);
      exp_short = sat_add(exp_short, sh);
      exp_long  = sat_add(exp_long, lg);
      for (int b = 0; b < chunk_q[c]; b++) begin
        endb = (b == chunk_q[c] - 1);
        d = 8'($urandom);
        k = 1'($urandom);
        e.tdata = d;
        e.tkeep = k;
        e.tlast = endb && fin;
        exp_q.push_back(e);
        send_beat(d, k, endb && (!fin || final_tlast), endb && fin);
        if (lat_check && first) begin
          #1;
          checks++;
          assert (axis_out_tvalid === 1'b1 && axis_out_tdata === d) else begin
            errors++;
            $error("FAIL latency: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                   axis_out_tvalid, axis_out_tdata, d);
          end
        end
        first = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) idle_input();
      end
    end
    last_len = (total > SAT) ? SAT : total;
    exp_len_q.push_back(last_len);
  endtask

  task automatic drain_and_check(input string tag);
    int w;
    int n;
    w = 0;
    while ((got_q.size() < exp_q.size() || got_len_q.size() < exp_len_q.size()) && w < 2000) begin
      @(negedge clock);
      w++;
    end
    repeat (4) @(negedge clock);
    checks++;
    assert (got_q.size() === exp_q.size()) else begin
      errors++;
      $error("FAIL %s beat_count: got=%0d required=%0d", tag, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (got_q[i] === exp_q[i]) else begin
        errors++;
        $error("FAIL %s beat%0d {data,keep,last}: got=%h required=%h", tag, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    assert (got_len_q.size() === exp_len_q.size()) else begin
      errors++;
      $error("FAIL %s pkt_done_count: got=%0d required=%0d", tag, got_len_q.size(), exp_len_q.size());
    end
    n = (got_len_q.size() < exp_len_q.size()) ? got_len_q.size() : exp_len_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (got_len_q[i] === exp_len_q[i]) else begin
        errors++;
        $error("FAIL %s pkt_len%0d: got=%0d required=%0d", tag, i, got_len_q[i], exp_len_q[i]);
      end
    end
    checks++;
    assert (short_err_cnt === CNT_W'(exp_short)) else begin
      errors++;
      $error("FAIL %s short_err_cnt: got=%0d required=%0d", tag, short_err_cnt, exp_short);
    end
    checks++;
    assert (long_err_cnt === CNT_W'(exp_long)) else begin
      errors++;
      $error("FAIL %s long_err_cnt: got=%0d required=%0d", tag, long_err_cnt, exp_long);
    end
    checks++;
    assert (pkt_len === CNT_W'(last_len)) else begin
      errors++;
      $error("FAIL %s pkt_len_hold: got=%0d required=%0d", tag, pkt_len, last_len);
    end
    got_q.delete();
    exp_q.delete();
    got_len_q.delete();
    exp_len_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nch;
    // Reset state
    repeat (3) @(negedge clock);
    checks++;
    assert (axis_in_tready === 1'b0 && axis_out_tvalid === 1'b0 && axis_out_tdata === 8'h00 &&
            axis_out_tkeep === 1'b0 && axis_out_tlast === 1'b0 && pkt_done === 1'b0) else begin
      errors++;
      $error("FAIL reset_io: tready=%0b tvalid=%0b data=%h keep=%0b last=%0b done=%0b required all 0",
             axis_in_tready, axis_out_tvalid, axis_out_tdata, axis_out_tkeep, axis_out_tlast, pkt_done);
    end
    checks++;
    assert (pkt_len === 5'd0 && short_err_cnt === 5'd0 && long_err_cnt === 5'd0) else begin
      errors++;
      $error("FAIL reset_cnt: pkt_len=%0d short=%0d long=%0d required 0",
             pkt_len, short_err_cnt, long_err_cnt);
    end
    rst = 1'b0;
    @(negedge clock);
    checks++;
    assert (axis_in_tready === 1'b1) else begin
      errors++;
      $error("FAIL ready_after_reset: got=%0b required=1", axis_in_tready);
    end

    // 10-beat packet as 4/4/2, with first-beat latency check
    length = 32'd4;
    checks++;
    assert (axis_out_tvalid === 1'b0) else begin
      errors++;
      $error("FAIL idle_tvalid: got=%0b required=0", axis_out_tvalid);
    end
    chunk_q = '{4, 4, 2};
    final_tlast = 1'b1;
    lat_check = 1'b1;
    send_packet(1'b0);
    lat_check = 1'b0;
    idle_input();
    drain_and_check("t1_split");

    // Short chunk of 3, then 4/1
    chunk_q = '{3, 4, 1};
    send_packet(1'b0);
    idle_input();
    drain_and_check("t2_short");

    // 6 beats without tlast, tuser on the last
    chunk_q = '{6};
    final_tlast = 1'b0;
    send_packet(1'b0);
    idle_input();
    drain_and_check("t3_long");

    // Toggling downstream ready, three 5-beat packets at length 2
    ready_mode = 1;
    length = 32'd2;
    final_tlast = 1'b1;
    for (int p = 0; p < 3; p++) begin
      chunk_q = '{2, 2, 1};
      send_packet(1'b0);
    end
    idle_input();
    drain_and_check("t4_toggle");
    checks++;
    assert (stall_viol === 0) else begin
      errors++;
      $error("FAIL t4 stall_stability: violations=%0d required=0", stall_viol);
    end
    ready_mode = 0;

    // Checking disabled
    length = 32'd0;
    chunk_q = '{1, 7, 3};
    final_tlast = 1'($urandom);
    send_packet(1'b0);
    idle_input();
    drain_and_check("t5_len0");

    // Randomised packets, lengths and downstream ready
    ready_mode = 2;
    for (int p = 0; p < 8; p++) begin
      length = 32'($urandom_range(0, 5));
      final_tlast = 1'($urandom);
      nch = $urandom_range(1, 4);
      chunk_q.delete();
      for (int c = 0; c < nch; c++) chunk_q.push_back($urandom_range(1, 7));
      send_packet(1'b1);
    end
    idle_input();
    ready_mode = 0;
    drain_and_check("t6_random");

    // Saturation: 35 one-beat short chunks then a final beat
    length = 32'd4;
    final_tlast = 1'b1;
    chunk_q.delete();
    for (int c = 0; c < 36; c++) chunk_q.push_back(1);
    send_packet(1'b0);
    idle_input();
    drain_and_check("t7_saturate");

    // Reset after beat 3 of an 8-beat packet; the third beat is still buffered
    for (int b = 0; b < 3; b++) begin
      skid_payload_t e;
      e.tdata = 8'(8'h40 + b);
      e.tkeep = 1'b1;
      e.tlast = 1'b0;
      if (b < 2) exp_q.push_back(e);
      send_beat(e.tdata, 1'b1, 1'b0, 1'b0);
    end
    ready_mode = 3;
    @(negedge clock);
    rst = 1'b1;
    axis_in_tvalid = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    checks++;
    assert (axis_out_tvalid === 1'b0 && axis_in_tready === 1'b0) else begin
      errors++;
      $error("FAIL post_reset: tvalid=%0b tready=%0b required 0/0", axis_out_tvalid, axis_in_tready);
    end
    ready_mode = 0;
    exp_short = 0;
    exp_long = 0;
    last_len = 0;
    drain_and_check("t8_reset");
    chunk_q = '{4};
    final_tlast = 1'b1;
    send_packet(1'b0);
    idle_input();
    drain_and_check("t8_after_reset");

    checks++;
    assert (stall_viol === 0) else begin
      errors++;
      $error("FAIL stall_stability_total: violations=%0d required=0", stall_viol);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
